nr_iter_sequencer: RTL

- Top-level controller for the Broyden/Newton-Raphson iteration datapath.
- Holds the current x vector (3 x fp32) and the inverse-Jacobian estimate (12 x fp32), and drives them into the iteration datapath.
- Launches each iteration, waits for the datapath completion strobe with a minimum-settle and watchdog bound, then latches the updated x and invJ.
- Tests convergence in ULP distance and repeats until converged, the iteration limit is hit, or abort/timeout.

---
 rtl/nr_iter_sequencer_if.sv | 33 +++
 rtl/nr_iter_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nr_iter_sequencer_if.sv
// nr_iter_sequencer_if: link between the Newton-Raphson sequencer
// and its iteration datapath.
interface nr_iter_sequencer_if;

  // sequencer -> datapath
  logic [95:0]  iter_x;
  logic [383:0] iter_invJ;
  logic         iter_launch;

  // datapath -> sequencer
  logic [95:0]  iter_out_x;
  logic [383:0] iter_next_invJ;
  logic         iter_stb;

  modport master (
    output iter_x,
    output iter_invJ,
    output iter_launch,
    input  iter_out_x,
    input  iter_next_invJ,
    input  iter_stb
  );

  modport slave (
    input  iter_x,
    input  iter_invJ,
    input  iter_launch,
    output iter_out_x,
    output iter_next_invJ,
    output iter_stb
  );

endinterface

// File: rtl/nr_iter_sequencer.sv
// nr_iter_sequencer: owns x and invJ, launches datapath iterations
// and stops on ULP convergence, iteration limit, abort or watchdog.
module nr_iter_sequencer #(
  parameter int MAX_ITER = 32,
  parameter int MIN_WAIT = 940,
  parameter int MAX_WAIT = 2047,
  parameter int TOL_ULP  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [95:0]         init_x,
  input  logic [383:0]        init_invJ,
  nr_iter_sequencer_if.master dp,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic                err_timeout,
  output logic [7:0]          iter_count,
  output logic [95:0]         result_x
);

  localparam logic [11:0] MIN_W    = 12'(MIN_WAIT);
  localparam logic [11:0] MAX_W    = 12'(MAX_WAIT);
  localparam logic [7:0]  ITER_LIM = 8'(MAX_ITER);
  localparam logic [31:0] TOL      = 32'(TOL_ULP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [95:0]   x_q;
  logic [95:0]   x_d;
  logic [383:0]  j_q;
  logic [383:0]  j_d;
  logic [11:0]   wait_q;
  logic [11:0]   wait_d;
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_d;
  logic          stb_q;
  logic          stb_d;
  logic          conv_q;
  logic          conv_d;
  logic          tmo_q;
  logic          tmo_d;

  logic          conv;
  logic          stb_rise;
  logic          edge_ok;
  logic          active;
  logic [7:0]    cnt_inc;

  // Raw fp32 distance in ULPs; opposite signs straddle zero.
  function automatic logic [31:0] ulp_dist(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] ma;
    logic [31:0] mb;
    ma = {1'b0, a[30:0]};
    mb = {1'b0, b[30:0]};
    if (a[31] != b[31]) begin
      return ma + mb;
    end
    return (ma >= mb) ? (ma - mb) : (mb - ma);
  endfunction

  // All three components within tolerance of the held x.
  always_comb begin
    conv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (ulp_dist(dp.iter_out_x[32*k +: 32],
                   x_q[32*k +: 32]) > TOL) begin
        conv = 1'b0;
      end
    end
  end

  assign stb_rise = dp.iter_stb & ~stb_q;
  assign edge_ok  = stb_rise && (wait_q >= MIN_W);
  assign cnt_inc  = cnt_q + 8'd1;
  assign active   = state_q inside {S_LOAD, S_LAUNCH,
                                    S_WAIT, S_CHECK};

  // Next-state and register updates; abort beats everything.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    j_d     = j_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;
    stb_d   = dp.iter_stb;
    if (abort && active) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          x_d     = init_x;
          j_d     = init_invJ;
          cnt_d   = 8'd0;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_LAUNCH;
        end
        S_LAUNCH: begin
          wait_d  = 12'd0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          wait_d = wait_q + 12'd1;
          if (edge_ok) begin
            state_d = S_CHECK;
          end else if (wait_q == MAX_W) begin
            tmo_d   = 1'b1;
            state_d = S_FIN;
          end
        end
        S_CHECK: begin
          x_d   = dp.iter_out_x;
          j_d   = dp.iter_next_invJ;
          cnt_d = cnt_inc;
          if (conv) begin
            conv_d  = 1'b1;
            state_d = S_FIN;
          end else if (cnt_inc == ITER_LIM) begin
            state_d = S_FIN;
          end else begin
            state_d = S_LAUNCH;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath-operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      j_q     <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      j_q     <= j_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      conv_q  <= conv_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dp.iter_x      = x_q;
  assign dp.iter_invJ   = j_q;
  assign dp.iter_launch = (state_q == S_LAUNCH);

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign converged   = conv_q;
  assign err_timeout = tmo_q;
  assign iter_count  = cnt_q;
  assign result_x    = x_q;

endmodule
